// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: opcodes from ALUController,
// the handshake FSM states, and the shift-amount width for a 32-bit datapath.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_EQ   = 4'b1000,
        OP_NE   = 4'b1001,
        OP_GE   = 4'b1010,
        OP_LT   = 4'b1100,
        OP_JUMP = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_ex_stage_comb_ops.sv
// Single-cycle ALU functions: logic, add/sub and signed/equality compares.
// Shift opcodes and unassigned codes yield zero here; shifts are handled by the stage.
module alu_comb_ops
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (operation)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = a + b;
            OP_XOR:  y = a ^ b;
            OP_SUB:  y = a - b;
            OP_EQ:   y = DATA_WIDTH'(a == b);
            OP_NE:   y = DATA_WIDTH'(a != b);
            OP_GE:   y = DATA_WIDTH'($signed(a) >= $signed(b));
            OP_LT:   y = DATA_WIDTH'($signed(a) <  $signed(b));
            OP_JUMP: y = DATA_WIDTH'(1);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute-stage ALU with valid/ready handshake. Non-shift ops finish in one cycle;
// shifts iterate SHIFT_STEP bit positions per cycle in the SHIFT state.
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    localparam int SHW    = $clog2(DATA_WIDTH);
    // One extra bit so SHIFT_STEP == DATA_WIDTH is representable.
    localparam int STEP_W = SHW + 1;
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(SHIFT_STEP);

    alu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]        count_q, count_d;
    logic [3:0]            shop_q, shop_d;

    logic [DATA_WIDTH-1:0] comb_y;
    logic [DATA_WIDTH-1:0] acc_shifted;
    logic [SHW-1:0]        shamt;
    logic [STEP_W-1:0]     count_ext;
    logic [STEP_W-1:0]     step;
    logic                  accept;
    logic                  is_shift;

    alu_comb_ops #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_comb_ops (
        .operation(operation),
        .a        (src_a),
        .b        (src_b),
        .y        (comb_y)
    );

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT);
    assign result    = result_q;
    assign accept    = in_valid && in_ready;
    assign shamt     = src_b[SHW-1:0];
    assign is_shift  = (operation == OP_SLL) || (operation == OP_SRL) || (operation == OP_SRA);

    // One iteration of the shifter: never move past the remaining count.
    always_comb begin
        count_ext = {1'b0, count_q};
        step      = (count_ext < STEP_MAX) ? count_ext : STEP_MAX;
        case (shop_q)
            OP_SLL:  acc_shifted = acc_q << step;
            OP_SRA:  acc_shifted = $unsigned($signed(acc_q) >>> step);
            default: acc_shifted = acc_q >> step;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        acc_d    = acc_q;
        count_d  = count_q;
        shop_d   = shop_q;
        case (state_q)
            SHIFT: begin
                acc_d   = acc_shifted;
                count_d = SHW'(count_ext - step);
                if (count_d == '0) begin
                    result_d = acc_shifted;
                    state_d  = DONE;
                end
            end
            default: begin
                if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = src_a;
                        count_d = shamt;
                        shop_d  = operation;
                        state_d = SHIFT;
                    end else begin
                        result_d = is_shift ? src_a : comb_y;
                        state_d  = DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            shop_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            shop_q   <= shop_d;
        end
    end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code produced by ALUController, together with two 32-bit operands.
- Returns a registered result over a valid/ready handshake.
- Logic, arithmetic and compare ops complete in one cycle. Shifts run through an iterative shifter, SHIFT_STEP bit positions per cycle, to keep the barrel shifter out of the critical path.
- Sits between the ID/EX operand mux and the EX/MEM writeback/branch logic.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHIFT_STEP, 1, bit positions shifted per cycle. Power of two, 1..DATA_WIDTH. SHIFT_STEP=DATA_WIDTH gives single-cycle shifts.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation/operands valid.
- in_ready  out  1  stage can accept this cycle.
- operation  in  4  ALU opcode from ALUController.
- src_a  in  DATA_WIDTH  operand A (shift source).
- src_b  in  DATA_WIDTH  operand B; shift amount = src_b[$clog2(DATA_WIDTH)-1:0].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  DATA_WIDTH  registered result.
- busy  out  1  high in SHIFT state.

Behaviour:
- Opcodes:
  - Logic/arithmetic: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB (wrap mod 2^32, no flags).
  - Shifts: 0100 SLL, 0101 SRL, 0111 SRA.
  - Compares: 1000 EQ, 1001 NE, 1010 GE (signed), 1100 LT (signed; shared by SLT/SLTI/BLT). Compare ops return 32'd1 or 32'd0.
  - 1101 JUMP: result 32'd1 (unconditional taken).
  - 1011, 1110, 1111: result 0, single-cycle, no error signalled.
- Reset (async, any state): state=IDLE, result=0, count=0. Outputs: out_valid=0, busy=0, in_ready=1. A transaction in flight is dropped silently.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational and does not depend on in_valid.
- Accept = in_valid && in_ready. Inputs are sampled only on the accept edge and ignored otherwise.
- On accept of a non-shift op:
  - result <= f(src_a, src_b); next state DONE.
  - out_valid is high in the cycle immediately after the accept edge (latency 1).
- On accept of a shift with shamt==0: result <= src_a; next state DONE (latency 1).
- On accept of a shift with shamt n>0:
  - acc <= src_a, count <= n; next state SHIFT.
  - Each SHIFT edge shifts acc by min(SHIFT_STEP, count) and decrements count by the same amount.
  - SRA fills with the original sign bit; SLL/SRL fill with 0.
  - When count reaches 0: result <= acc, state DONE.
  - out_valid rises ceil(n/SHIFT_STEP) cycles later than for a non-shift op.
- DONE:
  - out_valid=1; result is held stable while out_ready=0.
  - out_ready=1 with no accept: IDLE next.
  - out_ready=1 with an accept in the same cycle: the new op is processed as from IDLE (back-to-back, 1 op/cycle for non-shifts).
- out_valid=0 in IDLE and SHIFT. result keeps its last value in IDLE.
- in_ready=0 throughout SHIFT. An in_valid asserted during SHIFT is held upstream, not lost.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum with the 4-bit encodings above, shared with ALUController's users.
  - alu_state_e (IDLE/SHIFT/DONE).
  - Localparam SHAMT_W = $clog2(DATA_WIDTH).
- One sub-module, alu_comb_ops: purely combinational non-shift ops (operation, a, b -> y).
- The FSM and iterative shifter stay in alu_ex_stage.

Test Plan:
- ADD, 0x7FFFFFFF + 0x00000001, out_ready=1 -> out_valid one cycle after accept, result 0x80000000. SUB 0 - 1 -> 0xFFFFFFFF.
- SRA and SRL, src_a=0x80000000, src_b=4, SHIFT_STEP=1:
  - SRA -> busy for 4 cycles, out_valid 5 cycles after accept, result 0xF8000000.
  - SRL -> 0x08000000.
- SLL, src_a=1, src_b=0x00000025 -> only 5 LSBs used, result 0x00000020. SLL with src_b=0 -> latency 1, result=src_a.
- Compares: LT(0xFFFFFFFF, 1)=1; GE(0xFFFFFFFF, 1)=0; EQ(5,5)=1; NE(5,5)=0; JUMP=1; opcode 1111 -> 0.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in DONE -> result stable, in_ready=0.
  - Then raise out_ready with in_valid high (XOR 0xF0F0 ^ 0x0FF0) -> accepted that cycle, next result 0x0000FF00.
  - 10 consecutive ADDs with out_ready=1 -> one result per cycle.
- Assert reset mid-SHIFT (count=3) -> out_valid=0, busy=0, in_ready=1, result=0 immediately. No stale result after release.
